// File: rtl/fb_arbiter.sv
// fb_arbiter: single-port frame buffer arbiter between VGA scan-out reads
// and buffered camera writes.
//
// Reads win every cycle where vga_video_on=1 and vga_x is even. Every other
// cycle is a write slot that drains one entry from an in-order write FIFO.
// The frame buffer is FB_W x FB_H. The display scales it 2x in both
// directions: each even-x read is shown for two pixels, and lines 2k and 2k+1
// read the same row.
//
// Optional feature: define FB_OVF_CNT_EN to add the ovf_count port. It counts
// dropped camera requests and saturates at 65535.
//
// Ports:
//   pclk          pixel clock; all logic uses the rising edge
//   rst           synchronous reset, active low
//   vga_x/vga_y   current scan position from the VGA timing generator
//   vga_video_on  high inside the 640x480 active area
//   cam_wr_*      camera write request (valid/ready) with address and RGB444 data
//   mem_*         single-port RAM interface; mem_rdata arrives one cycle after mem_addr
//   pix_data      pixel to the DAC, two cycles after its (vga_x, vga_y)
//   pix_valid     vga_video_on delayed to line up with pix_data
//   ovf_count     dropped camera requests (FB_OVF_CNT_EN only)
module fb_arbiter #(
    parameter int FB_W       = 320,
    parameter int FB_H       = 240,
    parameter int WBUF_DEPTH = 4
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic [9:0]  vga_x,
    input  logic [9:0]  vga_y,
    input  logic        vga_video_on,
    input  logic        cam_wr_valid,
    input  logic [16:0] cam_wr_addr,
    input  logic [11:0] cam_wr_data,
    output logic        cam_wr_ready,
    output logic [16:0] mem_addr,
    output logic        mem_we,
    output logic [11:0] mem_wdata,
    input  logic [11:0] mem_rdata,
    output logic [11:0] pix_data,
    output logic        pix_valid
`ifdef FB_OVF_CNT_EN
    ,
    output logic [15:0] ovf_count
`endif
);

    localparam int PTR_W = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WBUF_DEPTH);
    localparam logic [17:0]      FB_SIZE  = 18'(FB_W * FB_H);

    logic [16:0]      buf_addr [WBUF_DEPTH];
    logic [11:0]      buf_data [WBUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             run;
    logic [16:0]      last_addr;
    logic [11:0]      last_wdata;
    logic             rd_d1;
    logic             von_d1;

    logic             read_slot;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             in_range;
    logic [19:0]      row_base;
    logic [16:0]      rd_addr;

    // Only vga_y[9:1] selects a row, so vga_y[0] is intentionally ignored.
    logic             unused_y_lsb;
    assign unused_y_lsb = vga_y[0];

    // Row base = (vga_y>>1)*FB_W. It is built from one shifted copy of the
    // row per set bit of FB_W. For FB_W=320 that is (row<<8) + (row<<6).
    always_comb begin
        row_base = '0;
        for (int i = 0; i < 20; i++) begin
            if (FB_W[i]) row_base = row_base + (20'(vga_y[9:1]) << i);
        end
    end

    assign rd_addr   = 17'(row_base + 20'(vga_x[9:1]));
    assign read_slot = vga_video_on & ~vga_x[0];
    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);

    // run is low for the first cycle after reset is released, so ready
    // cannot rise in the same cycle that rst returns high.
    assign cam_wr_ready = rst & run & ~full;
    assign push         = cam_wr_valid & cam_wr_ready;
    assign pop          = rst & ~read_slot & ~empty;
    assign in_range     = ({1'b0, buf_addr[rd_ptr]} < FB_SIZE);

    // The RAM port is driven combinationally so that a read issued in cycle t
    // returns its data in t+1 and is registered into pix_data at t+2.
    always_comb begin
        mem_addr  = last_addr;
        mem_wdata = last_wdata;
        mem_we    = 1'b0;
        if (!rst) begin
            mem_addr  = '0;
            mem_wdata = '0;
        end else if (read_slot) begin
            mem_addr = rd_addr;
        end else if (!empty) begin
            mem_addr  = buf_addr[rd_ptr];
            mem_wdata = buf_data[rd_ptr];
            // Out-of-range entries still leave the FIFO but never write the RAM.
            mem_we    = in_range;
        end
    end

    // FIFO storage has no reset: an entry is only read after it has been written.
    always_ff @(posedge pclk) begin
        if (push) begin
            buf_addr[wr_ptr] <= cam_wr_addr;
            buf_data[wr_ptr] <= cam_wr_data;
        end
    end

    always_ff @(posedge pclk) begin
        if (!rst) begin
            run        <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            last_addr  <= '0;
            last_wdata <= '0;
            rd_d1      <= 1'b0;
            von_d1     <= 1'b0;
            pix_data   <= '0;
            pix_valid  <= 1'b0;
        end else begin
            run        <= 1'b1;
            last_addr  <= mem_addr;
            last_wdata <= mem_wdata;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            // Stage 1 records whether this cycle issued a read.
            // Stage 2 captures the returned data.
            rd_d1     <= read_slot;
            von_d1    <= vga_video_on;
            pix_valid <= von_d1;
            if (!von_d1) begin
                pix_data <= '0;
            end else if (rd_d1) begin
                pix_data <= mem_rdata;
            end
            // An odd-x pixel keeps the previous even-x value (2x horizontal).
        end
    end

`ifdef FB_OVF_CNT_EN
    always_ff @(posedge pclk) begin
        if (!rst) begin
            ovf_count <= '0;
        end else if (cam_wr_valid && !cam_wr_ready && (ovf_count != 16'hFFFF)) begin
            ovf_count <= ovf_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fb_arbiter.sv
module tb_fb_arbiter;

    logic        pclk = 1'b0;
    logic        rst;
    logic [9:0]  vga_x;
    logic [9:0]  vga_y;
    logic        vga_video_on;
    logic        cam_wr_valid;
    logic [16:0] cam_wr_addr;
    logic [11:0] cam_wr_data;
    logic        cam_wr_ready;
    logic [16:0] mem_addr;
    logic        mem_we;
    logic [11:0] mem_wdata;
    logic [11:0] mem_rdata;
    logic [11:0] pix_data;
    logic        pix_valid;
`ifdef FB_OVF_CNT_EN
    logic [15:0] ovf_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [11:0] ram [0:131071];

    always #5 pclk = ~pclk;

    fb_arbiter dut (
        .pclk         (pclk),
        .rst          (rst),
        .vga_x        (vga_x),
        .vga_y        (vga_y),
        .vga_video_on (vga_video_on),
        .cam_wr_valid (cam_wr_valid),
        .cam_wr_addr  (cam_wr_addr),
        .cam_wr_data  (cam_wr_data),
        .cam_wr_ready (cam_wr_ready),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .pix_data     (pix_data),
        .pix_valid    (pix_valid)
`ifdef FB_OVF_CNT_EN
        ,
        .ovf_count    (ovf_count)
`endif
    );

    // Synchronous single-port RAM model: read data is available one cycle
    // after the address is presented.
    always @(posedge pclk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge. Checks run 1 ns after that.
    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    typedef struct packed {
        logic        von;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        exp_we;
        logic [16:0] exp_addr;
    } vec_t;

    vec_t vecs [9];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 131072; i++) ram[i] = 12'h000;
        ram[965] = 12'h5A5;
        ram[966] = 12'h123;

        vecs[0] = '{1'b1, 10'd10,  10'd7,   1'b0, 17'd965};
        vecs[1] = '{1'b1, 10'd11,  10'd7,   1'b0, 17'd965};
        vecs[2] = '{1'b1, 10'd0,   10'd0,   1'b0, 17'd0};
        vecs[3] = '{1'b1, 10'd638, 10'd479, 1'b0, 17'd76799};
        vecs[4] = '{1'b1, 10'd639, 10'd479, 1'b0, 17'd76799};
        vecs[5] = '{1'b1, 10'd2,   10'd1,   1'b0, 17'd1};
        vecs[6] = '{1'b1, 10'd100, 10'd3,   1'b0, 17'd370};
        vecs[7] = '{1'b1, 10'd101, 10'd3,   1'b0, 17'd370};
        vecs[8] = '{1'b0, 10'd700, 10'd3,   1'b0, 17'd370};

        rst = 1'b0; vga_x = 10'd700; vga_y = 10'd0; vga_video_on = 1'b0;
        cam_wr_valid = 1'b0; cam_wr_addr = '0; cam_wr_data = '0;

        // Reset state
        repeat (3) tick();
        chk("rst_ready", 32'(cam_wr_ready), 32'd0);
        chk("rst_we",    32'(mem_we),       32'd0);
        chk("rst_addr",  32'(mem_addr),     32'd0);
        chk("rst_wdata", 32'(mem_wdata),    32'd0);
        chk("rst_pix",   32'(pix_data),     32'd0);
        chk("rst_pvld",  32'(pix_valid),    32'd0);
`ifdef FB_OVF_CNT_EN
        chk("rst_ovf",   32'(ovf_count),    32'd0);
`endif
        rst = 1'b1;
        #1;
        chk("rel_ready_same_cycle", 32'(cam_wr_ready), 32'd0);
        tick();
        #1;
        chk("rel_ready_next_cycle", 32'(cam_wr_ready), 32'd1);

        // Read address mapping and address hold in empty write slots
        for (int i = 0; i < 9; i++) begin
            tick();
            vga_video_on = vecs[i].von; vga_x = vecs[i].x; vga_y = vecs[i].y;
            #1;
            chk($sformatf("vec%0d_we", i),   32'(mem_we),   32'(vecs[i].exp_we));
            chk($sformatf("vec%0d_addr", i), 32'(mem_addr), 32'(vecs[i].exp_addr));
        end

        // Pixel pipeline, 2x horizontal replication, video_on falling edge
        tick(); vga_video_on = 1'b1; vga_y = 10'd7; vga_x = 10'd10; #1;
        chk("pix_rd_addr", 32'(mem_addr), 32'd965);
        chk("pix_rd_we",   32'(mem_we),   32'd0);
        tick(); vga_x = 10'd11;
        tick(); vga_x = 10'd12; #1;
        chk("pix_x10_data", 32'(pix_data), 32'h5A5);
        chk("pix_x10_vld",  32'(pix_valid), 32'd1);
        tick(); vga_x = 10'd13; #1;
        chk("pix_x11_data", 32'(pix_data), 32'h5A5);
        chk("pix_x11_vld",  32'(pix_valid), 32'd1);
        tick(); vga_x = 10'd640; vga_video_on = 1'b0; #1;
        chk("pix_x12_data", 32'(pix_data), 32'h123);
        tick(); vga_x = 10'd641; #1;
        chk("pix_x13_data", 32'(pix_data), 32'h123);
        chk("pix_x13_vld",  32'(pix_valid), 32'd1);
        tick(); vga_x = 10'd642; #1;
        chk("pix_off_data", 32'(pix_data), 32'd0);
        chk("pix_off_vld",  32'(pix_valid), 32'd0);

        // Four writes during blanking, one per cycle, in order
        for (int c = 0; c < 6; c++) begin
            tick();
            cam_wr_valid = (c < 4);
            cam_wr_addr  = 17'(c);
            cam_wr_data  = 12'(12'hA01 + c);
            #1;
            chk($sformatf("blank_ready%0d", c), 32'(cam_wr_ready), 32'd1);
            if (c >= 1 && c <= 4) begin
                chk($sformatf("blank_we%0d", c),    32'(mem_we),    32'd1);
                chk($sformatf("blank_addr%0d", c),  32'(mem_addr),  32'(c - 1));
                chk($sformatf("blank_wdata%0d", c), 32'(mem_wdata), 32'(12'hA01 + c - 1));
            end else begin
                chk($sformatf("blank_we%0d", c), 32'(mem_we), 32'd0);
            end
        end
        cam_wr_valid = 1'b0;
        tick();
        chk("blank_ram3", 32'(ram[3]), 32'hA04);

        // Active line with the camera pushing every cycle
        for (int c = 0; c < 10; c++) begin
            tick();
            vga_video_on = 1'b1; vga_x = 10'(c); vga_y = 10'd0;
            cam_wr_valid = 1'b1;
            cam_wr_addr  = 17'(1000 + c);
            cam_wr_data  = 12'(12'h100 + c);
            #1;
            chk($sformatf("act_ready%0d", c), 32'(cam_wr_ready),
                (c <= 6) ? 32'd1 : 32'((c % 2) == 0));
            chk($sformatf("act_we%0d", c), 32'(mem_we), 32'(c % 2));
            if ((c % 2) == 1) begin
                chk($sformatf("act_addr%0d", c),  32'(mem_addr),  32'(1000 + (c - 1) / 2));
                chk($sformatf("act_wdata%0d", c), 32'(mem_wdata), 32'(12'h100 + (c - 1) / 2));
            end
        end
        tick();
        cam_wr_valid = 1'b0; vga_video_on = 1'b0; vga_x = 10'd700;
`ifdef FB_OVF_CNT_EN
        #1;
        chk("act_ovf", 32'(ovf_count), 32'd2);
`endif
        repeat (6) tick();
        chk("act_ram1003", 32'(ram[1003]), 32'h103);
        chk("act_ram1007", 32'(ram[1007]), 32'h000);
        chk("act_ram1008", 32'(ram[1008]), 32'h108);

        // Out-of-range address is popped but not written
        tick(); cam_wr_valid = 1'b1; cam_wr_addr = 17'd76800; cam_wr_data = 12'hFFF;
        tick(); cam_wr_addr = 17'd5; cam_wr_data = 12'h055; #1;
        chk("oor_we", 32'(mem_we), 32'd0);
        tick(); cam_wr_valid = 1'b0; #1;
        chk("oor_next_we",   32'(mem_we),   32'd1);
        chk("oor_next_addr", 32'(mem_addr), 32'd5);
        tick();
        tick();
        chk("oor_ram76800", 32'(ram[76800]), 32'h000);
        chk("oor_ram5",     32'(ram[5]),     32'h055);

        // Reset with three writes still buffered
        for (int c = 0; c < 3; c++) begin
            tick();
            vga_video_on = 1'b1; vga_x = 10'd0; vga_y = 10'd0;
            cam_wr_valid = 1'b1;
            cam_wr_addr  = 17'(2000 + c);
            cam_wr_data  = 12'(12'h200 + c);
            #1;
            chk($sformatf("hold_we%0d", c), 32'(mem_we), 32'd0);
        end
        chk("hold_pix", 32'(pix_data), 32'hA01);
        tick(); cam_wr_valid = 1'b0; rst = 1'b0; #1;
        chk("mrst_we",    32'(mem_we),       32'd0);
        chk("mrst_addr",  32'(mem_addr),     32'd0);
        chk("mrst_ready", 32'(cam_wr_ready), 32'd0);
        tick();
        chk("mrst_pix",   32'(pix_data),  32'd0);
        chk("mrst_pvld",  32'(pix_valid), 32'd0);
        rst = 1'b1; vga_video_on = 1'b0; vga_x = 10'd700;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk($sformatf("post_we%0d", c), 32'(mem_we), 32'd0);
        end
        chk("post_ready",   32'(cam_wr_ready), 32'd1);
        chk("post_ram2000", 32'(ram[2000]),    32'h000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fb_arbiter.md
FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 Parameter FB_W, default 320, frame buffer width in pixels (half of 640 active).
REQ-002 Parameter FB_H, default 240, frame buffer height in lines (half of 480 active).
REQ-003 Parameter WBUF_DEPTH, default 4, camera write buffer entries (power of two, >=2).
REQ-004 pclk  in  1  pixel clock; single clock domain; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 vga_x  in  10  current pixel column from VGA timing, 0..799.
REQ-007 vga_y  in  10  current line from VGA timing, 0..524.
REQ-008 vga_video_on  in  1  high inside the 640x480 active area.
REQ-009 cam_wr_valid  in  1  camera pixel write request.
REQ-010 cam_wr_addr  in  17  frame buffer word address of the camera pixel.
REQ-011 cam_wr_data  in  12  RGB444 camera pixel.
REQ-012 cam_wr_ready  out  1  write buffer can accept; a transfer occurs when valid and ready are both high.
REQ-013 mem_addr  out  17  single-port frame buffer RAM address.
REQ-014 mem_we  out  1  RAM write enable.
REQ-015 mem_wdata  out  12  RAM write data.
REQ-016 mem_rdata  in  12  RAM read data, valid one cycle after address is presented.
REQ-017 pix_data  out  12  pixel to VGA DAC.
REQ-018 pix_valid  out  1  vga_video_on delayed to align with pix_data.
REQ-019 ovf_count  out  16  dropped camera writes (present only with FB_OVF_CNT_EN).

Function
REQ-020 Read slot = cycle with vga_video_on=1 and vga_x[0]=0; every other cycle is a write slot.
REQ-021 In a read slot: mem_addr = (vga_y>>1)*FB_W + (vga_x>>1), mem_we=0; product computed by shift-add (FB_W=320: <<8 plus <<6), no multiplier.
REQ-022 Reads have absolute priority; a write is never issued in a read slot.
REQ-023 In a write slot with buffer non-empty: pop head, drive mem_addr/mem_wdata from it, mem_we=1, same cycle.
REQ-024 Write slot with buffer empty: mem_we=0, mem_addr holds last value.
REQ-025 Buffer entries whose address >= FB_W*FB_H are popped normally but issued with mem_we=0 (discarded).
REQ-026 Write buffer is in-order FIFO of WBUF_DEPTH entries; writes reach RAM in acceptance order.
REQ-027 cam_wr_ready = not full, registered-free (combinational from occupancy); simultaneous push and pop when not full keeps occupancy unchanged.
REQ-028 Pop in a write slot while full frees a slot; ready rises the following cycle, not same cycle.
REQ-029 cam_wr_valid while cam_wr_ready=0: request dropped, no buffer change.
REQ-030 Pixel latency: pix_data and pix_valid reflect the (vga_x, vga_y) sampled 2 cycles earlier.
REQ-031 pix_data registers mem_rdata for pixels whose read was issued; odd-x pixel repeats the preceding even-x value (2x horizontal replication).
REQ-032 pix_data = 0 whenever the delayed vga_video_on is 0.
REQ-033 Vertical replication: lines 2k and 2k+1 read identical addresses.

Reset
REQ-034 While rst=0 at a pclk edge: buffer empty, cam_wr_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, pix_data=0, pix_valid=0, ovf_count=0.
REQ-035 cam_wr_ready rises the first cycle after rst returns high.
REQ-036 Reset mid-operation discards all buffered writes; no partial write issued.

Configuration
REQ-037 Macro FB_OVF_CNT_EN defined: ovf_count present, increments by 1 per dropped request (REQ-029), saturates at 65535.
REQ-038 FB_OVF_CNT_EN undefined: ovf_count port and counter logic absent; all other behaviour identical.

Verification
REQ-039 Blanking (video_on=0), push 4 writes addr 0..3 data 0xA01..0xA04 -> mem_we=1 on 4 consecutive cycles, same order, cam_wr_ready never low.
REQ-040 video_on=1, x=10,y=7 -> mem_addr=3*320+5=965, mem_we=0; mem_rdata=0x5A5 -> pix_data=0x5A5, pix_valid=1 two cycles later and again for x=11.
REQ-041 Active line, camera pushes every cycle -> one write per odd-x cycle, buffer fills, ready low after 4 net pushes; with FB_OVF_CNT_EN, ovf_count counts each dropped cycle.
REQ-042 Write to addr 76800 -> popped with mem_we=0; RAM contents unchanged.
REQ-043 Assert rst=0 with 3 buffered writes -> next cycle all outputs zero, no further mem_we, buffer empty after release.
REQ-044 video_on falls at x=640 -> pix_valid=0 and pix_data=0 two cycles later.
